// File: rtl/uart_robot_tx_arbiter.sv
// Round-robin frame scheduler sharing one wide-frame UART transmitter between
// NUM_REQ command sources, with a completion watchdog and an inter-frame gap.
module uart_robot_tx_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 112,
  parameter  int GAP_CYCLES     = 4340,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_flag,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [GW-1:0]                 grant_id,
  output logic                          frame_done,
  output logic                          timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          last_q, last_d, grant_q, grant_d, win_id;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          gap_q, gap_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0]     ready_q, ready_d;
  logic                   flag_q, flag_d, fdone_q, fdone_d, terr_q, terr_d;
  logic                   busy_q, busy_d, win_vld;

  // First pending requester searching upward from the one after the last winner.
  always_comb begin
    int            j;
    logic [GW-1:0] cand;
    j       = 0;
    cand    = '0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = GW'(j);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    data_d  = data_q;
    grant_d = grant_q;
    ready_d = '0;
    flag_d  = 1'b0;
    fdone_d = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          data_d          = req_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
          grant_d         = win_id;
          last_d          = win_id;
          ready_d[win_id] = 1'b1;
          flag_d          = 1'b1;
          timer_d         = '0;
          state_d         = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // The watchdog window opens after the start-pulse cycle, so the
        // expiry pulse lands TIMEOUT_CYCLES+1 cycles after tx_flag.
        if (!flag_q) timer_d = timer_q + 1'b1;
        if (tx_done || (!flag_q && timer_q == TMR_LAST)) begin
          fdone_d = tx_done;
          terr_d  = !tx_done;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      timer_q <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ready_q <= '0;
      flag_q  <= 1'b0;
      fdone_q <= 1'b0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      flag_q  <= flag_d;
      fdone_q <= fdone_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready   = ready_q;
  assign tx_data     = data_q;
  assign tx_flag     = flag_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign frame_done  = fdone_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/uart_robot_tx_arbiter.md
# uart_robot_tx_arbiter

Round-robin frame scheduler that shares one wide-frame UART robot transmitter (`pi_data`/`pi_flag`/`tx_done` interface) between `NUM_REQ` command sources, such as servo-angle, gripper and status generators.
- Accepts one whole frame per requester handshake.
- Launches it on the transmitter and holds the payload stable for the entire transmission.
- Waits for completion or a watchdog timeout, then enforces an inter-frame idle gap before the next grant.
- Sits between the command generators and the transmitter instance.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `DATA_WIDTH`, 112: frame width in bits. Must equal the transmitter's `DATA_WIDTH`.
- `GAP_CYCLES`, 4340: idle `sys_clk` cycles between frames. 0 means no gap.
- `TIMEOUT_CYCLES`, 100000: maximum cycles to wait for `tx_done`. Must be at least 1.
- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: bit i means requester i has a frame pending.
- `req_data` in `NUM_REQ*DATA_WIDTH`: flattened payloads. Requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out `NUM_REQ`: one-hot, one-cycle accept pulse.
- `tx_data` out `DATA_WIDTH`: drives the transmitter's `pi_data`.
- `tx_flag` out 1: one-cycle start pulse that drives `pi_flag`.
- `tx_done` in 1: transmitter completion pulse.
- `busy` out 1: high whenever state is not IDLE.
- `grant_id` out `max(1,$clog2(NUM_REQ))`: requester currently owning the transmitter.
- `frame_done` out 1: one-cycle pulse on successful completion.
- `timeout_err` out 1: one-cycle pulse on watchdog expiry.

## Operation
- FSM has three states: IDLE, WAIT_DONE, GAP. Reset state is IDLE.
- Requester rules:
  - Raise `req_valid[i]` and hold `req_valid[i]` and its `req_data` slice stable until `req_ready[i]` is seen.
  - Drop or replace the frame the cycle after `req_ready[i]`.
- IDLE, when `req_valid` is nonzero:
  - Pick winner g as the first set bit searching upward from (`last`+1) mod `NUM_REQ`.
  - Registered updates on that edge: `tx_data` ← slice g, `grant_id` ← g, `last` ← g, `req_ready` ← onehot(g), `tx_flag` ← 1, timer ← 0, state ← WAIT_DONE.
- Reset value of `last` is `NUM_REQ`-1, so requester 0 has first priority.
- WAIT_DONE:
  - Timer increments every cycle.
  - `tx_data` and `grant_id` are frozen, because the transmitter reads `pi_data` live throughout the transmission.
  - `tx_flag` is never re-asserted; a second `pi_flag` would restart the transmitter.
  - If `tx_done` is high: `frame_done` ← 1, state ← GAP (or IDLE if `GAP_CYCLES`=0), gap counter ← 0.
  - Else if timer == `TIMEOUT_CYCLES`-1: `timeout_err` ← 1, then the same transitions as `tx_done`.
  - If `tx_done` and timer expiry coincide, `tx_done` wins and `timeout_err` stays 0.
- GAP:
  - Count to `GAP_CYCLES`-1, then go to IDLE.
  - Incoming `req_valid` is ignored until IDLE.
- Stray `tx_done` seen in IDLE or GAP is ignored; no pulse is generated.
- Counter widths:
  - Timer: `$clog2(TIMEOUT_CYCLES+1)`, saturates only by state exit.
  - Gap counter: `$clog2(GAP_CYCLES+1)`.
  - Round-robin search is modulo `NUM_REQ`.
- Asynchronous reset mid-frame:
  - All outputs go to their reset values immediately: `tx_data`, `grant_id`, `req_ready`, `tx_flag`, `frame_done`, `timeout_err` and `busy` all 0.
  - `last` goes to `NUM_REQ`-1 and state to IDLE.
  - Any pending request is re-arbitrated after release; no frame is lost from the requester's view, since it was never acknowledged or it is resent by its owner.

## Timing
- Request sampled at edge E:
  - `req_ready`, `tx_flag` and the new `tx_data` are all visible in cycle E+1.
  - `busy` is high from E+1.
- `tx_done` high in cycle D: `frame_done` is high in D+1, and GAP starts at D+1.
- Earliest next grant edge is at D+1+`GAP_CYCLES`; its `tx_flag` is visible one cycle later.
- With `GAP_CYCLES`=0, the earliest back-to-back `tx_flag` is 2 cycles after `tx_done`.
- Timeout: `timeout_err` is high exactly `TIMEOUT_CYCLES`+1 cycles after the `tx_flag` cycle if no `tx_done` arrives.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Single request:** `req_valid`=0001, payload 0x0123…CDEF, transmitter model returns `tx_done` 60760 cycles later. Required response:
  - One `tx_flag`.
  - `tx_data` stable for the full frame.
  - `frame_done` with `grant_id`=0.
  - `busy` low again after 4340 gap cycles.
- **Round-robin:** `req_valid`=1111 held continuously with re-arm. Grant order must be 0,1,2,3,0. Each `req_ready` is a single-cycle one-hot pulse.
- **Timeout:** `TIMEOUT_CYCLES`=100, `tx_done` never arrives. `timeout_err` must pulse 101 cycles after `tx_flag`, `frame_done` must stay 0, and the next requester is granted after the gap.
- **Coincident completion:** `tx_done` asserted in the same cycle the timer hits 99. Required: `frame_done`=1 and `timeout_err`=0.
- **Reset mid-frame:** `sys_rst_n` pulsed low in WAIT_DONE. All outputs must be 0 asynchronously. With `req_valid`=0100 held, the first grant after release is requester 2.
- **Back-to-back:** `GAP_CYCLES`=0, `req_valid`=0011. Second `tx_flag` exactly 2 cycles after the first `tx_done`. A stray `tx_done` injected in IDLE produces no `frame_done`.
